cdf_engine: RTL and testbench

Parametrised, self-sequencing cumulative-distribution engine for the histogram-equalisation pipeline. Reads NUM_BINS histogram counts from scratch memory, BINS_PER_WORD bins per word. Writes the running prefix sums back to a separate scratch region and reports the first non-zero CDF value (cdf_min) and the grand total. Replaces the externally sequenced CDF datapath: it owns its own FSM, a start/done handshake and a variable-latency read port.

---
 rtl/cdf_engine.sv | 216 +++++++++++++++++++++
 tb/tb_cdf_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_engine.sv
// Self-sequencing CDF engine: reads packed histogram words, writes running prefix sums, reports cdf_min/cdf_total.
// Optional CDF_SAT_EN: saturating prefix adds plus a sat_flag output pulsing with WE.

module cdf_lane #(
  parameter int BIN_W = 32
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [BIN_W-1:0] i_bin,
`ifdef CDF_SAT_EN
  input  logic             i_sat,
  output logic             o_sat,
`endif
  output logic [BIN_W-1:0] o_sum
);
`ifdef CDF_SAT_EN
  logic [BIN_W:0] w_full;
  assign w_full = {1'b0, i_acc} + {1'b0, i_bin};
  // once anything upstream clipped, every later lane stays pinned at max
  assign o_sat  = i_sat | w_full[BIN_W];
  assign o_sum  = o_sat ? '1 : w_full[BIN_W-1:0];
`else
  assign o_sum  = i_acc + i_bin;
`endif
endmodule

module cdf_engine #(
  parameter  int BIN_W         = 32,
  parameter  int BINS_PER_WORD = 4,
  parameter  int NUM_BINS      = 256,
  parameter  int ADDR_W        = 16,
  parameter  int RD_BASE       = 0,
  parameter  int WR_BASE       = 64,
  localparam int DATA_W        = BIN_W * BINS_PER_WORD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteBus,
`ifdef CDF_SAT_EN
  output logic              sat_flag,
`endif
  output logic [BIN_W-1:0]  cdf_min,
  output logic [BIN_W-1:0]  cdf_total
);
  localparam int BPW       = BINS_PER_WORD;
  localparam int NUM_WORDS = NUM_BINS / BINS_PER_WORD;
  localparam int K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
  localparam logic [K_W-1:0]    K_LAST    = K_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;
  state_t r_state, w_next;

  logic [K_W-1:0]            r_k;
  logic [BIN_W-1:0]          r_cdf_prev, r_cdf_min, r_cdf_total;
  logic                      r_min_found;
  logic [ADDR_W-1:0]         r_rd_addr, r_wr_addr;
  // slot BPW-1 holds bin 0 so the packed vector matches the bus lane order
  logic [BPW-1:0][BIN_W-1:0] r_wbus, w_bus, w_rd;
  logic [BIN_W-1:0]          w_bin  [BPW];
  logic [BIN_W-1:0]          w_acc  [BPW];
  logic [BIN_W-1:0]          w_lane [BPW];
  logic                      w_last, w_min_hit;
  logic [BIN_W-1:0]          w_min_val;
`ifdef CDF_SAT_EN
  logic                      r_sat, r_word_sat;
  logic                      w_sin  [BPW];
  logic                      w_sout [BPW];
`endif

  assign w_rd   = rd_data;
  assign w_last = (r_k == K_LAST);

  for (genvar j = 0; j < BPW; j++) begin : g_lane
    assign w_bin[j] = w_rd[BPW-1-j];
    if (j == 0) begin : g_first
      assign w_acc[j] = r_cdf_prev;
`ifdef CDF_SAT_EN
      assign w_sin[j] = r_sat;
`endif
    end else begin : g_chain
      assign w_acc[j] = w_lane[j-1];
`ifdef CDF_SAT_EN
      assign w_sin[j] = w_sout[j-1];
`endif
    end
    cdf_lane #(.BIN_W(BIN_W)) u_lane (
      .i_acc (w_acc[j]),
      .i_bin (w_bin[j]),
`ifdef CDF_SAT_EN
      .i_sat (w_sin[j]),
      .o_sat (w_sout[j]),
`endif
      .o_sum (w_lane[j])
    );
    assign w_bus[BPW-1-j] = w_lane[j];
  end

  // lowest-index non-zero lane of the word being written
  always_comb begin
    w_min_hit = 1'b0;
    w_min_val = '0;
    for (int j = BPW - 1; j >= 0; j--) begin
      if (r_wbus[BPW-1-j] != '0) begin
        w_min_hit = 1'b1;
        w_min_val = r_wbus[BPW-1-j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    rd_en  = 1'b0;
    WE     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RD;
      S_RD: begin
        busy   = 1'b1;
        rd_en  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (rd_valid) w_next = S_WR;
      end
      S_WR: begin
        busy   = 1'b1;
        WE     = 1'b1;
        w_next = w_last ? S_FIN : S_RD;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k         <= '0;
      r_cdf_prev  <= '0;
      r_cdf_min   <= '0;
      r_cdf_total <= '0;
      r_min_found <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wbus      <= '0;
`ifdef CDF_SAT_EN
      r_sat       <= 1'b0;
      r_word_sat  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_k         <= '0;
          r_cdf_prev  <= '0;
          r_cdf_min   <= '0;
          r_min_found <= 1'b0;
          r_rd_addr   <= RD_BASE_A;
`ifdef CDF_SAT_EN
          r_sat       <= 1'b0;
`endif
        end
        S_WAIT: if (rd_valid) begin
          r_wbus    <= w_bus;
          r_wr_addr <= WR_BASE_A + ADDR_W'(r_k);
`ifdef CDF_SAT_EN
          r_word_sat <= w_sout[BPW-1];
`endif
        end
        S_WR: begin
          r_cdf_prev <= r_wbus[0];
`ifdef CDF_SAT_EN
          r_sat      <= r_word_sat;
`endif
          if (!r_min_found && w_min_hit) begin
            r_cdf_min   <= w_min_val;
            r_min_found <= 1'b1;
          end
          if (!w_last) begin
            r_k       <= r_k + K_W'(1);
            r_rd_addr <= RD_BASE_A + ADDR_W'(r_k) + ADDR_W'(1);
          end
        end
        S_FIN: r_cdf_total <= r_cdf_prev;
        default: ;
      endcase
    end
  end

  assign rd_addr      = r_rd_addr;
  assign WriteAddress = r_wr_addr;
  assign WriteBus     = r_wbus;
  assign cdf_min      = r_cdf_min;
  assign cdf_total    = r_cdf_total;
`ifdef CDF_SAT_EN
  assign sat_flag     = WE & r_word_sat;
`endif
endmodule

// File: tb/tb_cdf_engine.sv
// Directed bench for cdf_engine: memory responder with programmable read latency, write capture, per-scenario tasks.
module tb_cdf_engine;
  localparam int NW  = 64;
  localparam int WRB = 64;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, rd_valid = 1'b0;
  logic         busy, done, rd_en, WE;
  logic [15:0]  rd_addr, WriteAddress;
  logic [127:0] rd_data = '0;
  logic [127:0] WriteBus;
  logic [31:0]  cdf_min, cdf_total;
`ifdef CDF_SAT_EN
  logic         sat_flag;
  logic [NW-1:0] satw, exp_sat;
`endif

  int checks = 0, errors = 0;
  logic [127:0] mem [NW];
  logic [127:0] cap [NW];
  logic [127:0] exp_w [NW];
  logic [31:0]  exp_min, exp_tot;
  int wcnt = 0, rcnt = 0, lat = 1, cnt = 0, spur = 0, raddr = 0;

  cdf_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .WE(WE), .WriteAddress(WriteAddress), .WriteBus(WriteBus),
`ifdef CDF_SAT_EN
    .sat_flag(sat_flag),
`endif
    .cdf_min(cdf_min), .cdf_total(cdf_total)
  );

  always #5 clk = ~clk;

  // read responder: data returned lat cycles after the rd_en cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      cnt = 0; rd_valid = 1'b0;
    end else begin
      rd_valid = 1'b0;
      if (spur > 0) begin rd_valid = 1'b1; rd_data = '1; spur--; end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin rd_valid = 1'b1; rd_data = mem[raddr]; end
      end
      if (rd_en) begin cnt = lat; raddr = int'(rd_addr[5:0]); end
    end
  end

  always @(negedge clk) begin
    if (WE) begin
      if (int'(WriteAddress) >= WRB && int'(WriteAddress) < WRB + NW) begin
        cap[int'(WriteAddress) - WRB] = WriteBus;
`ifdef CDF_SAT_EN
        satw[int'(WriteAddress) - WRB] = sat_flag;
`endif
      end
      wcnt++;
    end
    if (rd_en) rcnt++;
  end

  task automatic build_exp();
    logic [32:0] s;
    logic [31:0] acc, b;
    logic found;
`ifdef CDF_SAT_EN
    logic st;
    st = 1'b0;
`endif
    acc = '0; found = 1'b0; exp_min = '0;
    for (int w = 0; w < NW; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = mem[w][127-32*j -: 32];
        s = {1'b0, acc} + {1'b0, b};
`ifdef CDF_SAT_EN
        if (st || s[32]) begin st = 1'b1; acc = '1; end
        else acc = s[31:0];
`else
        acc = s[31:0];
`endif
        exp_w[w][127-32*j -: 32] = acc;
        if (!found && acc != 0) begin found = 1'b1; exp_min = acc; end
      end
`ifdef CDF_SAT_EN
      exp_sat[w] = st;
`endif
    end
    exp_tot = acc;
  endtask

  function automatic int count_bad();
    int n = 0;
    for (int w = 0; w < NW; w++) if (cap[w] !== exp_w[w]) n++;
    return n;
  endfunction

  task automatic clear_cap();
    for (int w = 0; w < NW; w++) cap[w] = 'x;
    wcnt = 0; rcnt = 0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int w = 0; w < NW; w++) mem[w] = {v, v, v, v};
  endtask

  // start-to-done cycle count; 2000 means done never came
  task automatic run_pass(input int l, output int cyc);
    lat = l;
    @(negedge clk);
    clear_cap();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, WE} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, rd_en, WE});
    end
    checks++;
    if (rd_addr !== 16'd0 || WriteAddress !== 16'd0) begin
      errors++; $display("FAIL reset_addr: got rd=%0d wr=%0d want 0/0", rd_addr, WriteAddress);
    end
    checks++;
    if (WriteBus !== 128'd0 || cdf_min !== 32'd0 || cdf_total !== 32'd0) begin
      errors++; $display("FAIL reset_data: got bus=%h min=%h tot=%h want 0", WriteBus, cdf_min, cdf_total);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ones();
    int cyc, bad;
    fill(32'd1); build_exp();
    run_pass(1, cyc);
    checks++;
    if (cyc != 193) begin errors++; $display("FAIL ones_latency: got %0d cycles want 193", cyc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ones_words: got %0d bad words want 0", bad); end
    checks++;
    if (cap[0] !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("FAIL ones_word0: got %h want 1,2,3,4", cap[0]);
    end
    checks++;
    if (cap[63] !== {32'd253, 32'd254, 32'd255, 32'd256} || WriteAddress !== 16'd127) begin
      errors++; $display("FAIL ones_last: got %h @%0d want 253..256 @127", cap[63], WriteAddress);
    end
    checks++;
    if (cdf_min !== 32'd1 || cdf_total !== 32'd256) begin
      errors++; $display("FAIL ones_minmax: got min=%0d tot=%0d want 1/256", cdf_min, cdf_total);
    end
    checks++;
    if (wcnt != 64 || rcnt != 64) begin
      errors++; $display("FAIL ones_counts: got we=%0d rd=%0d want 64/64", wcnt, rcnt);
    end
  endtask

  task automatic test_sparse();
    int cyc, bad;
    fill(32'd0); mem[2][63:32] = 32'd5; build_exp();
    run_pass(1, cyc);
    @(negedge clk);
    checks++;
    if (cdf_min !== 32'd5 || cdf_total !== 32'd5) begin
      errors++; $display("FAIL sparse_minmax: got min=%0d tot=%0d want 5/5", cdf_min, cdf_total);
    end
    checks++;
    if (cap[1] !== 128'd0 || cap[2] !== {32'd0, 32'd0, 32'd5, 32'd5} || cap[63] !== {4{32'd5}}) begin
      errors++; $display("FAIL sparse_words: got w1=%h w2=%h w63=%h", cap[1], cap[2], cap[63]);
    end
    fill(32'd0); build_exp();
    run_pass(1, cyc);
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (cdf_min !== 32'd0 || cdf_total !== 32'd0 || bad != 0) begin
      errors++; $display("FAIL zero_pass: got min=%0d tot=%0d bad=%0d want 0/0/0", cdf_min, cdf_total, bad);
    end
    for (int w = 0; w < NW; w++) mem[w] = {32'(w * 3), 32'(w + 7), 32'd0, 32'(w ^ 5)};
    build_exp();
    run_pass(1, cyc);
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (bad != 0 || cdf_min !== exp_min || cdf_total !== exp_tot) begin
      errors++; $display("FAIL mixed_pass: got bad=%0d min=%0d tot=%0d want 0/%0d/%0d", bad, cdf_min, cdf_total, exp_min, exp_tot);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    fill(32'd0); mem[0][127:96] = 32'hFFFF_FFFF; mem[0][95:64] = 32'd2;
    run_pass(1, cyc);
    @(negedge clk);
`ifdef CDF_SAT_EN
    checks++;
    if (cap[0] !== {4{32'hFFFF_FFFF}} || cdf_total !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_word0: got %h tot=%h want all-ones", cap[0], cdf_total);
    end
    checks++;
    if (satw[0] !== 1'b1 || satw[63] !== 1'b1) begin
      errors++; $display("FAIL sat_flag: got w0=%b w63=%b want 1/1", satw[0], satw[63]);
    end
`else
    checks++;
    if (cap[0] !== {32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1} || cdf_total !== 32'd1) begin
      errors++; $display("FAIL wrap_word0: got %h tot=%h want ffffffff,1,1,1 tot 1", cap[0], cdf_total);
    end
`endif
    checks++;
    if (cdf_min !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_min: got %h want ffffffff", cdf_min);
    end
  endtask

  task automatic test_latency();
    int cyc, bad;
    fill(32'd1); build_exp();
    run_pass(3, cyc);
    checks++;
    if (cyc != 321) begin errors++; $display("FAIL lat3_done: got %0d cycles want 321", cyc); end
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (bad != 0 || rcnt != 64 || wcnt != 64) begin
      errors++; $display("FAIL lat3_words: got bad=%0d rd=%0d we=%0d want 0/64/64", bad, rcnt, wcnt);
    end
    lat = 1;
    wcnt = 0;
    spur = 3;
    repeat (6) @(negedge clk);
    checks++;
    if (wcnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL spurious_valid: got we=%0d busy=%b want 0/0", wcnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    fill(32'd1); build_exp();
    lat = 1;
    @(negedge clk);
    clear_cap();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(WE && WriteAddress == 16'(WRB + 10)) && cyc < 500) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 500 || cdf_min !== 32'd1) begin
      errors++; $display("FAIL midreset_reach: got cyc=%0d min=%0d want word 10 min 1", cyc, cdf_min);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, WE, rd_en} !== 3'b000 || cdf_min !== 32'd0) begin
      errors++; $display("FAIL midreset_async: got busy/we/rd=%b min=%0d want 000/0", {busy, WE, rd_en}, cdf_min);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_pass(1, cyc);
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (cyc != 193 || bad != 0 || cdf_min !== 32'd1 || cdf_total !== 32'd256) begin
      errors++; $display("FAIL midreset_rerun: got cyc=%0d bad=%0d min=%0d tot=%0d want 193/0/1/256", cyc, bad, cdf_min, cdf_total);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bad;
    for (int w = 0; w < NW; w++) mem[w] = {32'(w), 32'd2, 32'(w + 1), 32'd0};
    build_exp();
    lat = 1;
    @(negedge clk);
    clear_cap();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      start = (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 193 || wcnt != 64) begin
      errors++; $display("FAIL busy_start: got cyc=%0d we=%0d want 193/64", cyc, wcnt);
    end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy=%b want 0", busy); end
    clear_cap();
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bad = count_bad();
    checks++;
    if (cyc != 193 || bad != 0 || cdf_min !== exp_min || cdf_total !== exp_tot) begin
      errors++; $display("FAIL second_pass: got cyc=%0d bad=%0d min=%0d tot=%0d want 193/0/%0d/%0d", cyc, bad, cdf_min, cdf_total, exp_min, exp_tot);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_sparse();
    test_wrap();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
